// File: rtl/ddr2_pipe_out_unpacker.sv
// Drains 32-bit DDR output-FIFO words and presents them to the host pipe as 16-bit half-words.
// Latency: ob_re, then ob_valid, then pipe_data valid on the third cycle from an empty buffer.
// Backpressure: a read issues only while fewer than two words are held or in flight, or one retires.
module ddr2_pipe_out_unpacker #(
    parameter int BLOCK_WORDS16 = 512,
    parameter bit LOW_FIRST     = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        flush,
    output logic        ob_re,
    input  logic [31:0] ob_data,
    input  logic        ob_valid,
    input  logic        ob_empty,
    input  logic [10:0] ob_count,
    input  logic        pipe_read,
    output logic [15:0] pipe_data,
    output logic        pipe_ready,
    output logic        underrun,
    output logic [31:0] words_sent
);

    logic [31:0] hold;
    logic [31:0] pf;
    logic        hold_full;
    logic        pf_full;
    logic        inflight;
    logic        half;

    logic [1:0]  occ;
    logic        consume;
    logic        retire;
    logic        issue;
    logic        ret;
    logic        load_hold;
    logic [12:0] hold_avail;
    logic [12:0] avail;

    assign occ       = 2'(hold_full) + 2'(pf_full) + 2'(inflight);
    assign consume   = pipe_read && hold_full && !flush;
    assign retire    = consume && half;
    assign issue     = enable && !ob_empty && !flush &&
                       ((occ < 2'd2) || ((occ == 2'd2) && retire));
    // Gated with reset so the strobe drops the moment reset asserts.
    assign ob_re     = issue && reset_n;
    assign ret       = ob_valid && inflight && !flush;
    assign load_hold = (!hold_full || retire) && !pf_full;

    // Half-words still deliverable: FIFO + prefetch + in-flight + what remains of hold.
    assign hold_avail = hold_full ? (half ? 13'd1 : 13'd2) : 13'd0;
    assign avail      = {1'b0, ob_count, 1'b0} + {11'd0, pf_full, 1'b0} +
                        {11'd0, inflight, 1'b0} + hold_avail;

    always_comb begin
        pipe_data = 16'h0000;
        if (hold_full) begin
            pipe_data = (half == LOW_FIRST) ? hold[31:16] : hold[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold       <= 32'h0;
            pf         <= 32'h0;
            hold_full  <= 1'b0;
            pf_full    <= 1'b0;
            inflight   <= 1'b0;
            half       <= 1'b0;
            words_sent <= 32'h0;
            underrun   <= 1'b0;
        end else if (flush) begin
            hold_full  <= 1'b0;
            pf_full    <= 1'b0;
            inflight   <= 1'b0;
            half       <= 1'b0;
            words_sent <= 32'h0;
            underrun   <= 1'b0;
        end else begin
            inflight <= issue || (inflight && !ob_valid);

            if (ret && load_hold) begin
                hold      <= ob_data;
                hold_full <= 1'b1;
            end else if (retire) begin
                hold      <= pf;
                hold_full <= pf_full;
            end

            if (ret && !load_hold) begin
                pf      <= ob_data;
                pf_full <= 1'b1;
            end else if (retire) begin
                pf_full <= 1'b0;
            end

            if (consume) begin
                half       <= !half;
                words_sent <= words_sent + 32'd1;
            end

            if (!enable) begin
                underrun <= 1'b0;
            end else if (pipe_read && !hold_full) begin
                underrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_ready <= 1'b0;
        end else begin
            pipe_ready <= (avail >= 13'(BLOCK_WORDS16));
        end
    end

endmodule

// File: tb/tb_ddr2_pipe_out_unpacker.sv
// Bench for ddr2_pipe_out_unpacker: FIFO model, half-word scoreboard, vector table and corner sequences.
module tb_ddr2_pipe_out_unpacker;

    localparam int BLOCK = 512;

    typedef struct {
        logic        en;
        logic        rd;
        logic [15:0] data;
        logic [31:0] sent;
        logic        und;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic        ob_re;
    logic [31:0] ob_data = 32'h0;
    logic        ob_valid = 1'b0;
    logic        ob_empty = 1'b1;
    logic [10:0] ob_count = 11'd0;
    logic        pipe_read = 1'b0;
    logic [15:0] pipe_data;
    logic        pipe_ready;
    logic        underrun;
    logic [31:0] words_sent;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] fifo_q [$];
    logic [15:0] expq [$];
    logic        m_inflight = 1'b0;
    logic        m_und = 1'b0;
    logic        m_ready = 1'b0;
    logic [31:0] m_sent = 32'h0;

    ddr2_pipe_out_unpacker #(.BLOCK_WORDS16(BLOCK), .LOW_FIRST(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
        .ob_re(ob_re), .ob_data(ob_data), .ob_valid(ob_valid), .ob_empty(ob_empty),
        .ob_count(ob_count), .pipe_read(pipe_read), .pipe_data(pipe_data),
        .pipe_ready(pipe_ready), .underrun(underrun), .words_sent(words_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input bit clr);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        pipe_read = 1'b0;
        flush = 1'b0;
        if (clr) fifo_q.delete();
        #1;
        chk("rst_ob_re", 32'(ob_re), 32'h0);
        chk("rst_pipe_data", 32'(pipe_data), 32'h0);
        chk("rst_pipe_ready", 32'(pipe_ready), 32'h0);
        chk("rst_underrun", 32'(underrun), 32'h0);
        chk("rst_words_sent", words_sent, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // FIFO model: read data returns one cycle after the strobe.
    always @(posedge clk) begin
        ob_valid <= 1'b0;
        if (ob_re && fifo_q.size() > 0) begin
            ob_data  <= fifo_q.pop_front();
            ob_valid <= 1'b1;
        end
        ob_count <= 11'(fifo_q.size());
        ob_empty <= (fifo_q.size() == 0);
    end

    // Scoreboard: queue of half-words the unpacker is holding, checked every cycle.
    initial begin
        int          sz;
        int          occ;
        logic        retire;
        logic        exp_re;
        logic [15:0] junk;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                chk("mon_rst_ob_re", 32'(ob_re), 32'h0);
                chk("mon_rst_pipe_data", 32'(pipe_data), 32'h0);
                chk("mon_rst_words_sent", words_sent, 32'h0);
                expq.delete();
                m_inflight = 1'b0;
                m_und = 1'b0;
                m_ready = 1'b0;
                m_sent = 32'h0;
            end else begin
                chk("mon_pipe_ready", 32'(pipe_ready), 32'(m_ready));
                chk("mon_words_sent", words_sent, m_sent);
                chk("mon_underrun", 32'(underrun), 32'(m_und));
                sz = expq.size();
                occ = (sz + 1) / 2 + int'(m_inflight);
                retire = pipe_read && !flush && (sz % 2 == 1);
                exp_re = enable && !ob_empty && !flush && ((occ < 2) || (occ == 2 && retire));
                chk("mon_ob_re", 32'(ob_re), 32'(exp_re));
                chk("mon_pipe_data", 32'(pipe_data), (sz > 0) ? 32'(expq[0]) : 32'h0);
                m_ready = (2 * int'(ob_count) + sz + 2 * int'(m_inflight)) >= BLOCK;
                if (flush) begin
                    expq.delete();
                    m_inflight = 1'b0;
                    m_und = 1'b0;
                    m_sent = 32'h0;
                end else begin
                    if (pipe_read) begin
                        if (sz > 0) begin
                            junk = expq.pop_front();
                            m_sent = m_sent + 32'd1;
                        end else if (enable) begin
                            m_und = 1'b1;
                        end
                    end
                    if (!enable) m_und = 1'b0;
                    if (ob_valid && m_inflight) begin
                        expq.push_back(ob_data[15:0]);
                        expq.push_back(ob_data[31:16]);
                        m_inflight = 1'b0;
                    end
                    if (exp_re) m_inflight = 1'b1;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tv [12];
        logic [31:0] w [4];
        logic [31:0] head;

        tv[0]  = '{1'b1, 1'b1, 16'h2222, 32'd0, 1'b0};
        tv[1]  = '{1'b1, 1'b1, 16'h1111, 32'd1, 1'b0};
        tv[2]  = '{1'b1, 1'b1, 16'h4444, 32'd2, 1'b0};
        tv[3]  = '{1'b1, 1'b1, 16'h3333, 32'd3, 1'b0};
        tv[4]  = '{1'b1, 1'b0, 16'h0000, 32'd4, 1'b0};
        tv[5]  = '{1'b1, 1'b1, 16'h0000, 32'd4, 1'b0};
        tv[6]  = '{1'b1, 1'b0, 16'h0000, 32'd4, 1'b1};
        tv[7]  = '{1'b1, 1'b0, 16'h0000, 32'd4, 1'b1};
        tv[8]  = '{1'b0, 1'b0, 16'h0000, 32'd4, 1'b1};
        tv[9]  = '{1'b0, 1'b0, 16'h0000, 32'd4, 1'b0};
        tv[10] = '{1'b1, 1'b1, 16'h0000, 32'd4, 1'b0};
        tv[11] = '{1'b1, 1'b0, 16'h0000, 32'd4, 1'b1};

        // Basic unpack order, first-word latency, then underrun behaviour.
        do_reset(1'b1);
        enable = 1'b1;
        @(negedge clk);
        fifo_q.push_back(32'h1111_2222);
        fifo_q.push_back(32'h3333_4444);
        @(negedge clk);
        chk("lat_cycle1_ob_re", 32'(ob_re), 32'h1);
        @(negedge clk);
        chk("lat_cycle2_pipe_data", 32'(pipe_data), 32'h0);
        @(negedge clk);
        chk("lat_cycle3_pipe_data", 32'(pipe_data), 32'h2222);
        @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) begin
            enable = tv[i].en;
            pipe_read = tv[i].rd;
            @(negedge clk);
            chk($sformatf("tv%0d_pipe_data", i), 32'(pipe_data), 32'(tv[i].data));
            chk($sformatf("tv%0d_words_sent", i), words_sent, tv[i].sent);
            chk($sformatf("tv%0d_underrun", i), 32'(underrun), 32'(tv[i].und));
            @(posedge clk);
            #1;
        end
        pipe_read = 1'b0;
        enable = 1'b1;

        // pipe_ready threshold, counting buffered words.
        do_reset(1'b1);
        enable = 1'b1;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            fifo_q.push_back(32'hC000_0000 | 32'(i));
        end
        @(negedge clk);
        chk("ready_at_512_edge", 32'(pipe_ready), 32'h0);
        @(negedge clk);
        chk("ready_one_after_512", 32'(pipe_ready), 32'h1);

        // Flush while a word is in flight.
        do_reset(1'b1);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) w[i] = 32'hA001_A000 + 32'(i) * 32'h0002_0002;
        @(negedge clk);
        for (int i = 0; i < 4; i++) fifo_q.push_back(w[i]);
        step(6);
        pipe_read = 1'b1;
        step(2);
        pipe_read = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_blocks_ob_re", 32'(ob_re), 32'h0);
        chk("flush_pre_words_sent", words_sent, 32'd2);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_pipe_data", 32'(pipe_data), 32'h0);
        chk("flush_words_sent", words_sent, 32'h0);
        chk("flush_next_ob_re", 32'(ob_re), 32'h1);
        @(negedge clk);
        @(negedge clk);
        chk("flush_next_word", 32'(pipe_data), 32'(w[3][15:0]));
        @(posedge clk);
        #1;
        pipe_read = 1'b1;
        step(2);
        pipe_read = 1'b0;

        // Continuous streaming with no bubbles.
        do_reset(1'b1);
        enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 1024; i++) fifo_q.push_back({16'(i) ^ 16'h5A5A, 16'(i)});
        step(6);
        pipe_read = 1'b1;
        step(2048);
        pipe_read = 1'b0;
        @(negedge clk);
        chk("stream_words_sent", words_sent, 32'd2048);
        chk("stream_underrun", 32'(underrun), 32'h0);
        chk("stream_drained", 32'(pipe_data), 32'h0);

        // Reset mid-stream restarts from the FIFO head.
        do_reset(1'b1);
        enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 20; i++) fifo_q.push_back({16'hB100 + 16'(i), 16'hB000 + 16'(i)});
        step(6);
        pipe_read = 1'b1;
        step(7);
        do_reset(1'b0);
        head = fifo_q[0];
        @(negedge clk);
        chk("rst_restart_ob_re", 32'(ob_re), 32'h1);
        @(negedge clk);
        @(negedge clk);
        chk("rst_restart_head", 32'(pipe_data), 32'(head[15:0]));
        chk("rst_restart_words_sent", words_sent, 32'h0);
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
